// File: rtl/banked_reg_file_if.sv
// banked_reg_file_if: decode-stage port bundle of the banked register file
interface banked_reg_file_if #(
  parameter int DATA_W      = 8,
  parameter int BANK_REGS   = 8,
  parameter int NUM_BANKS   = 2,
  parameter int GLOBAL_REGS = 8
);
  localparam int AW  = $clog2(BANK_REGS);
  localparam int FAW = $clog2(BANK_REGS + GLOBAL_REGS);
  localparam int BSW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  logic              write_reg;
  logic [AW-1:0]     reg_src1;
  logic [AW-1:0]     reg_src2;
  logic              full_addr;
  logic [FAW-1:0]    full_reg_src;
  logic [DATA_W-1:0] data_in;
  logic              copy_req;
  logic [BSW-1:0]    copy_src;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [BSW-1:0]    bank_sel;
  logic [1:0]        aro;
  logic              ldst;
  logic              busy;
  logic              write_ack;
  modport master (
    output write_reg, reg_src1, reg_src2, full_addr, full_reg_src, data_in, copy_req, copy_src,
    input  data1, data2, bank_sel, aro, ldst, busy, write_ack
  );
  modport slave (
    input  write_reg, reg_src1, reg_src2, full_addr, full_reg_src, data_in, copy_req, copy_src,
    output data1, data2, bank_sel, aro, ldst, busy, write_ack
  );
endinterface

// File: rtl/banked_reg_file.sv
// banked_reg_file: banked + global register file with SSB and hardware bank-copy sequencer
// Define BYPASS_EN to forward write data to same-cycle reads of the write destination.
module banked_reg_file #(
  parameter int DATA_W      = 8,
  parameter int BANK_REGS   = 8,
  parameter int NUM_BANKS   = 2,
  parameter int GLOBAL_REGS = 8
) (
  input logic CLK,
  input logic RST,
  banked_reg_file_if.slave bus
);
  localparam int AW    = $clog2(BANK_REGS);
  localparam int FAW   = $clog2(BANK_REGS + GLOBAL_REGS);
  localparam int BSW   = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  localparam int GW    = GLOBAL_REGS > 1 ? $clog2(GLOBAL_REGS) : 1;
  localparam int TOTAL = BANK_REGS + GLOBAL_REGS;
  typedef enum logic {IDLE, COPY} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] bank [NUM_BANKS][BANK_REGS];
  logic [DATA_W-1:0] glob [GLOBAL_REGS];
  logic [AW-1:0]     idx;
  logic [BSW-1:0]    src, dst_bank, sel, sat;
  logic [FAW-1:0]    addr;
  logic [AW-1:0]     lidx;
  logic [GW-1:0]     gidx;
  logic [DATA_W-1:0] ssb_in, d1, d2;
  logic              is_loc, is_glob, we, wr_ok, ssb_we, accept, busy;
  // port 1 and the write share one address, so the write destination is addr
  assign addr    = bus.full_addr ? bus.full_reg_src : FAW'(bus.reg_src1);
  assign lidx    = addr[AW-1:0];
  assign gidx    = GW'(addr - FAW'(BANK_REGS));
  assign is_loc  = int'(addr) < BANK_REGS;
  assign is_glob = !is_loc && int'(addr) < TOTAL;
  assign we      = bus.write_reg && !busy;
  assign wr_ok   = we && (is_loc ? lidx != '0 : is_glob);
  assign ssb_we  = we && is_glob && gidx == '0;
  assign sel     = glob[0][BSW-1:0];
  assign sat     = int'(bus.data_in[BSW-1:0]) >= NUM_BANKS ? BSW'(NUM_BANKS - 1) : bus.data_in[BSW-1:0];
  assign ssb_in  = {bus.data_in[DATA_W-1:BSW], sat};
  assign accept  = state == IDLE && bus.copy_req && bus.copy_src != sel &&
                   int'(bus.copy_src) < NUM_BANKS && !ssb_we;
  always_ff @(posedge CLK)
    if (RST) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (accept ? COPY : IDLE) : (idx == AW'(BANK_REGS - 1) ? IDLE : COPY);
  always_comb begin
    busy          = state == COPY;
    bus.busy      = busy;
    bus.write_ack = we;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx      <= '0;
      src      <= '0;
      dst_bank <= '0;
      for (int b = 0; b < NUM_BANKS; b++)
        for (int r = 0; r < BANK_REGS; r++) bank[b][r] <= '0;
      for (int g = 0; g < GLOBAL_REGS; g++) glob[g] <= '0;
    end else begin
      if (accept) begin
        idx      <= AW'(1);
        src      <= bus.copy_src;
        dst_bank <= sel;
      end else if (busy) idx <= idx + AW'(1);
      if (busy) bank[dst_bank][idx] <= bank[src][idx];
      if (wr_ok && is_loc) bank[sel][lidx] <= bus.data_in;
      if (wr_ok && is_glob) glob[gidx] <= gidx == '0 ? ssb_in : bus.data_in;
    end
  end
  always_comb begin
    d1 = is_loc ? (lidx == '0 ? '0 : bank[sel][lidx]) : is_glob ? glob[gidx] : '0;
    d2 = bus.reg_src2 == '0 ? '0 : bank[sel][bus.reg_src2];
`ifdef BYPASS_EN
    if (wr_ok) d1 = bus.data_in;
    if (wr_ok && is_loc && lidx == bus.reg_src2) d2 = bus.data_in;
`endif
    bus.data1    = d1;
    bus.data2    = d2;
    bus.bank_sel = sel;
    bus.aro      = glob[0][BSW+1:BSW];
    bus.ldst     = glob[0][BSW+2];
  end
endmodule
